// File: rtl/slave_port_mux_if.sv
// Bus bundle between one slave-port multiplexer, the four masters, the
// round-robin arbiter and the slave. The master modport is the mux side
// (it masters the slave bus); the slave modport is the environment side.
interface slave_port_mux_if;
    logic [2:0]  grant_num;
    logic        grant_req;
    logic [31:0] master_1_addr;
    logic [31:0] master_2_addr;
    logic [31:0] master_3_addr;
    logic [31:0] master_4_addr;
    logic        master_1_cmd;
    logic        master_2_cmd;
    logic        master_3_cmd;
    logic        master_4_cmd;
    logic [31:0] master_1_wdata;
    logic [31:0] master_2_wdata;
    logic [31:0] master_3_wdata;
    logic [31:0] master_4_wdata;
    logic        slave_ack;
    logic [31:0] slave_rdata;
    logic        slave_req;
    logic [31:0] slave_addr;
    logic        slave_cmd;
    logic [31:0] slave_wdata;
    logic        master_1_ack;
    logic        master_2_ack;
    logic        master_3_ack;
    logic        master_4_ack;
    logic [31:0] master_rdata;
    logic        resp_err;
    logic        arb_ack;
    logic        busy;

    modport master (
        input  grant_num, grant_req,
        input  master_1_addr, master_2_addr, master_3_addr, master_4_addr,
        input  master_1_cmd, master_2_cmd, master_3_cmd, master_4_cmd,
        input  master_1_wdata, master_2_wdata, master_3_wdata, master_4_wdata,
        input  slave_ack, slave_rdata,
        output slave_req, slave_addr, slave_cmd, slave_wdata,
        output master_1_ack, master_2_ack, master_3_ack, master_4_ack,
        output master_rdata, resp_err, arb_ack, busy
    );

    modport slave (
        output grant_num, grant_req,
        output master_1_addr, master_2_addr, master_3_addr, master_4_addr,
        output master_1_cmd, master_2_cmd, master_3_cmd, master_4_cmd,
        output master_1_wdata, master_2_wdata, master_3_wdata, master_4_wdata,
        output slave_ack, slave_rdata,
        input  slave_req, slave_addr, slave_cmd, slave_wdata,
        input  master_1_ack, master_2_ack, master_3_ack, master_4_ack,
        input  master_rdata, resp_err, arb_ack, busy
    );
endinterface

// File: rtl/slave_port_mux.sv
// Slave-port multiplexer: latches the granted master's transaction, holds it
// on the slave bus until slave_ack or a timeout, then returns a one-cycle
// response pulse to that master and to the arbiter. All outputs registered.
module slave_port_mux #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned SLAVE   = 0
) (
    input logic              clk,
    input logic              reset,
    slave_port_mux_if.master bus
);
    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("slave_port_mux[%0d]: TIMEOUT=%0d outside 1..255", SLAVE, TIMEOUT);
    end

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_mnum, w_mnum_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic        r_cmd, w_cmd_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic        r_req, w_req_nxt;
    logic [3:0]  r_mack, w_mack_nxt;
    logic        r_arb, w_arb_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_err, w_err_nxt;
    logic        r_busy;

    logic        w_sel_valid;
    logic [31:0] w_sel_addr;
    logic        w_sel_cmd;
    logic [31:0] w_sel_wdata;

    // Select the transaction fields of the master named by grant_num
    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_addr  = '0;
        w_sel_cmd   = 1'b0;
        w_sel_wdata = '0;
        case (bus.grant_num)
            3'd1: begin w_sel_addr = bus.master_1_addr; w_sel_cmd = bus.master_1_cmd; w_sel_wdata = bus.master_1_wdata; end
            3'd2: begin w_sel_addr = bus.master_2_addr; w_sel_cmd = bus.master_2_cmd; w_sel_wdata = bus.master_2_wdata; end
            3'd3: begin w_sel_addr = bus.master_3_addr; w_sel_cmd = bus.master_3_cmd; w_sel_wdata = bus.master_3_wdata; end
            3'd4: begin w_sel_addr = bus.master_4_addr; w_sel_cmd = bus.master_4_cmd; w_sel_wdata = bus.master_4_wdata; end
            default: w_sel_valid = 1'b0;
        endcase
    end

    // Next-state and next-output logic; pulses default low every cycle
    always_comb begin
        w_state_nxt = r_state;
        w_mnum_nxt  = r_mnum;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_cmd_nxt   = r_cmd;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_req_nxt   = 1'b0;
        w_mack_nxt  = '0;
        w_arb_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.grant_req && w_sel_valid) begin
                    w_mnum_nxt  = bus.grant_num;
                    w_addr_nxt  = w_sel_addr;
                    w_cmd_nxt   = w_sel_cmd;
                    w_wdata_nxt = w_sel_wdata;
                    w_cnt_nxt   = '0;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // An ack on the final wait cycle still wins over the timeout
                if (bus.slave_ack || r_cnt == TMO_LAST) begin
                    w_rdata_nxt = bus.slave_ack ? bus.slave_rdata : '0;
                    w_err_nxt   = !bus.slave_ack;
                    w_mack_nxt  = 4'b0001 << (r_mnum - 3'd1);
                    w_arb_nxt   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    w_req_nxt = 1'b1;
                end
            end
            RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_mnum  <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_cmd   <= 1'b0;
            r_wdata <= '0;
            r_req   <= 1'b0;
            r_mack  <= '0;
            r_arb   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mnum  <= w_mnum_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_cmd   <= w_cmd_nxt;
            r_wdata <= w_wdata_nxt;
            r_req   <= w_req_nxt;
            r_mack  <= w_mack_nxt;
            r_arb   <= w_arb_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign bus.slave_req    = r_req;
    assign bus.slave_addr   = r_addr;
    assign bus.slave_cmd    = r_cmd;
    assign bus.slave_wdata  = r_wdata;
    assign bus.master_1_ack = r_mack[0];
    assign bus.master_2_ack = r_mack[1];
    assign bus.master_3_ack = r_mack[2];
    assign bus.master_4_ack = r_mack[3];
    assign bus.master_rdata = r_rdata;
    assign bus.resp_err     = r_err;
    assign bus.arb_ack      = r_arb;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_slave_port_mux.sv
// Bench for slave_port_mux: a hand-written vector table, directed corner
// sequences and random traffic, all checked against a transaction-timeline
// reference model.
module tb_slave_port_mux;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    slave_port_mux_if bus ();

    slave_port_mux #(.TIMEOUT(TMO), .SLAVE(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int e = 0;

    // Reference model: one transaction at a time, described by the edge it
    // was accepted on and the edge its completion was decided on.
    bit          m_active = 1'b0;
    int          m_start  = 0;
    int          m_done   = -1;
    int          m_master = 0;
    logic [31:0] m_addr   = '0;
    logic        m_cmd    = 1'b0;
    logic [31:0] m_wdata  = '0;
    logic [31:0] m_rdata  = '0;
    logic        m_err    = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
        end
    endfunction

    function automatic logic [3:0] acks();
        return {bus.master_4_ack, bus.master_3_ack, bus.master_2_ack, bus.master_1_ack};
    endfunction

    function automatic void model_edge();
        if (reset) begin
            m_active = 1'b0; m_master = 0;
            m_addr = '0; m_cmd = 1'b0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
        end else if (m_active && m_done >= 0) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (bus.slave_ack) begin
                m_done = e; m_rdata = bus.slave_rdata; m_err = 1'b0;
            end else if (e - m_start == TMO) begin
                m_done = e; m_rdata = '0; m_err = 1'b1;
            end
        end else if (bus.grant_req && bus.grant_num >= 3'd1 && bus.grant_num <= 3'd4) begin
            m_active = 1'b1; m_start = e; m_done = -1; m_master = int'(bus.grant_num);
            case (m_master)
                1: begin m_addr = bus.master_1_addr; m_cmd = bus.master_1_cmd; m_wdata = bus.master_1_wdata; end
                2: begin m_addr = bus.master_2_addr; m_cmd = bus.master_2_cmd; m_wdata = bus.master_2_wdata; end
                3: begin m_addr = bus.master_3_addr; m_cmd = bus.master_3_cmd; m_wdata = bus.master_3_wdata; end
                default: begin m_addr = bus.master_4_addr; m_cmd = bus.master_4_cmd; m_wdata = bus.master_4_wdata; end
            endcase
        end
    endfunction

    function automatic void model_compare();
        bit          pulse;
        logic [3:0]  exp_acks;
        pulse    = m_active && (m_done == e);
        exp_acks = pulse ? 4'(1 << (m_master - 1)) : 4'h0;
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("slave_req", 32'(bus.slave_req), 32'(m_active && m_done < 0));
        chk("slave_addr", bus.slave_addr, m_addr);
        chk("slave_cmd", 32'(bus.slave_cmd), 32'(m_cmd));
        chk("slave_wdata", bus.slave_wdata, m_wdata);
        chk("master_acks", 32'(acks()), 32'(exp_acks));
        chk("arb_ack", 32'(bus.arb_ack), 32'(pulse));
        chk("master_rdata", bus.master_rdata, m_rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(m_err));
    endfunction

    task automatic step();
        @(posedge clk);
        e++;
        model_edge();
        #1;
        model_compare();
    endtask

    typedef struct {
        bit          rst;
        bit          greq;
        logic [2:0]  gnum;
        bit          sack;
        logic [31:0] srdata;
        bit          x_busy;
        bit          x_req;
        logic [31:0] x_addr;
        logic [3:0]  x_acks;
        bit          x_arb;
        logic [31:0] x_rdata;
        bit          x_err;
    } vec_t;

    vec_t vt[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_req;
        bit          got;
        int          e_ack;
        int          e_acc;
        logic [3:0]  pulses[$];
        logic [3:0]  a;
        int          stray;

        // read path on master 2, then spurious/illegal inputs in IDLE
        vt[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  4'h0, 1'b0, 32'h0,         1'b0};
        vt[1] = '{1'b0, 1'b1, 3'd2, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 4'h0, 1'b0, 32'h0,         1'b0};
        vt[2] = '{1'b0, 1'b0, 3'd2, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 4'h0, 1'b0, 32'h0,         1'b0};
        vt[3] = '{1'b0, 1'b0, 3'd2, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 4'h0, 1'b0, 32'h0,         1'b0};
        vt[4] = '{1'b0, 1'b0, 3'd2, 1'b1, 32'hCAFE0001,  1'b1, 1'b0, 32'h10, 4'h2, 1'b1, 32'hCAFE0001,  1'b0};
        vt[5] = '{1'b0, 1'b0, 3'd2, 1'b0, 32'h0,         1'b0, 1'b0, 32'h10, 4'h0, 1'b0, 32'hCAFE0001,  1'b0};
        vt[6] = '{1'b0, 1'b0, 3'd2, 1'b1, 32'hDEAD0000,  1'b0, 1'b0, 32'h10, 4'h0, 1'b0, 32'hCAFE0001,  1'b0};
        vt[7] = '{1'b0, 1'b1, 3'd0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h10, 4'h0, 1'b0, 32'hCAFE0001,  1'b0};
        vt[8] = '{1'b0, 1'b1, 3'd5, 1'b0, 32'h0,         1'b0, 1'b0, 32'h10, 4'h0, 1'b0, 32'hCAFE0001,  1'b0};

        bus.grant_num = 3'd0; bus.grant_req = 1'b0;
        bus.slave_ack = 1'b0; bus.slave_rdata = '0;
        bus.master_1_addr = 32'h1000; bus.master_1_cmd = 1'b1; bus.master_1_wdata = 32'h1111_1111;
        bus.master_2_addr = 32'h10;   bus.master_2_cmd = 1'b0; bus.master_2_wdata = 32'h2222_2222;
        bus.master_3_addr = 32'h3000; bus.master_3_cmd = 1'b0; bus.master_3_wdata = 32'h3333_3333;
        bus.master_4_addr = 32'h4000; bus.master_4_cmd = 1'b1; bus.master_4_wdata = 32'h4444_4444;

        for (int i = 0; i < 9; i++) begin
            reset = vt[i].rst; bus.grant_req = vt[i].greq; bus.grant_num = vt[i].gnum;
            bus.slave_ack = vt[i].sack; bus.slave_rdata = vt[i].srdata;
            step();
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].x_busy));
            chk($sformatf("vec%0d_req", i), 32'(bus.slave_req), 32'(vt[i].x_req));
            chk($sformatf("vec%0d_addr", i), bus.slave_addr, vt[i].x_addr);
            chk($sformatf("vec%0d_acks", i), 32'(acks()), 32'(vt[i].x_acks));
            chk($sformatf("vec%0d_arb", i), 32'(bus.arb_ack), 32'(vt[i].x_arb));
            chk($sformatf("vec%0d_rdata", i), bus.master_rdata, vt[i].x_rdata);
            chk($sformatf("vec%0d_err", i), 32'(bus.resp_err), 32'(vt[i].x_err));
        end
        bus.grant_req = 1'b0; bus.slave_ack = 1'b0;
        step();

        // hold stability: master 4 write, inputs change while BUSY
        bus.master_4_addr = 32'hA4A4_0040; bus.master_4_wdata = 32'h5EED_0004; bus.master_4_cmd = 1'b1;
        bus.grant_req = 1'b1; bus.grant_num = 3'd4;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.master_4_addr = $urandom; bus.master_4_wdata = $urandom; bus.master_4_cmd = 1'b0;
            bus.grant_num = 3'(1 + i);
            step();
            chk("hold_addr", bus.slave_addr, 32'hA4A4_0040);
            chk("hold_wdata", bus.slave_wdata, 32'h5EED_0004);
        end
        bus.slave_ack = 1'b1; bus.slave_rdata = 32'h0BAD_F00D;
        step();
        chk("hold_resp_addr", bus.slave_addr, 32'hA4A4_0040);
        chk("hold_resp_acks", 32'(acks()), 32'h8);
        bus.grant_req = 1'b0; bus.slave_ack = 1'b0;
        step();

        // timeout: no ack at all
        bus.grant_req = 1'b1; bus.grant_num = 3'd3;
        step();
        bus.grant_req = 1'b0;
        n_req = bus.slave_req ? 1 : 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (acks() != 4'h0) got = 1'b1;
            else if (bus.slave_req) n_req++;
        end
        chk("tmo_seen", 32'(got), 32'h1);
        chk("tmo_req_cycles", 32'(n_req), 32'(TMO));
        chk("tmo_acks", 32'(acks()), 32'h4);
        chk("tmo_err", 32'(bus.resp_err), 32'h1);
        chk("tmo_rdata", bus.master_rdata, 32'h0);
        step();

        // reset on the second BUSY cycle aborts without any ack
        bus.grant_req = 1'b1; bus.grant_num = 3'd1;
        step();
        bus.grant_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_req", 32'(bus.slave_req), 32'h0);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            bus.slave_ack = (i < 3);
            step();
            if (acks() != 4'h0 || bus.arb_ack) stray++;
        end
        chk("rst_no_ack", 32'(stray), 32'h0);

        // back-to-back: master 1 acked, master 3 grant held continuously
        bus.slave_ack = 1'b0;
        bus.grant_req = 1'b1; bus.grant_num = 3'd1;
        step();
        bus.grant_num = 3'd3; bus.slave_ack = 1'b1; bus.slave_rdata = 32'h0000_0B2B;
        step();
        e_ack = e;
        if (acks() != 4'h0) pulses.push_back(acks());
        bus.slave_ack = 1'b0;
        e_acc = -1;
        for (int i = 0; i < 8 && e_acc < 0; i++) begin
            step();
            if (acks() != 4'h0) pulses.push_back(acks());
            if (bus.slave_req) e_acc = e;
        end
        chk("b2b_accept_gap", 32'(e_acc - e_ack), 32'h2);
        bus.grant_req = 1'b0; bus.slave_ack = 1'b1;
        step();
        if (acks() != 4'h0) pulses.push_back(acks());
        bus.slave_ack = 1'b0;
        step();
        if (acks() != 4'h0) pulses.push_back(acks());
        chk("b2b_pulse_count", 32'(pulses.size()), 32'h2);
        a = (pulses.size() > 0) ? pulses[0] : 4'h0;
        chk("b2b_first", 32'(a), 32'h1);
        a = (pulses.size() > 1) ? pulses[1] : 4'h0;
        chk("b2b_second", 32'(a), 32'h4);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.grant_req = $urandom_range(0, 1);
            bus.grant_num = 3'($urandom_range(0, 7));
            bus.slave_ack = ($urandom_range(0, 4) == 0);
            bus.slave_rdata = $urandom;
            bus.master_1_addr = $urandom; bus.master_1_cmd = 1'($urandom); bus.master_1_wdata = $urandom;
            bus.master_2_addr = $urandom; bus.master_2_cmd = 1'($urandom); bus.master_2_wdata = $urandom;
            bus.master_3_addr = $urandom; bus.master_3_cmd = 1'($urandom); bus.master_3_wdata = $urandom;
            bus.master_4_addr = $urandom; bus.master_4_cmd = 1'($urandom); bus.master_4_wdata = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/slave_port_mux.md
SLAVE_PORT_MUX -- requirements
Module: slave_port_mux

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum number of BUSY cycles to wait for slave_ack (legal range 1..255).
REQ-002 Parameter: SLAVE, default 0, index of the slave port served; used only for identification.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 grant_num  in  3  granted master number from the round-robin arbiter: 1..4 are legal; 0 and 5..7 mean no grant.
REQ-006 grant_req  in  1  arbiter slave_req; a grant is valid only when grant_req=1.
REQ-007 master_k_addr  in  32  address from master k, k=1..4.
REQ-008 master_k_cmd  in  1  command from master k: 1=write, 0=read.
REQ-009 master_k_wdata  in  32  write data from master k.
REQ-010 slave_ack  in  1  slave completion strobe.
REQ-011 slave_rdata  in  32  slave read data, valid with slave_ack.
REQ-012 slave_req  out  1  request to the slave.
REQ-013 slave_addr / slave_cmd / slave_wdata  out  32/1/32  captured transaction fields.
REQ-014 master_k_ack  out  1  per-master completion pulse, k=1..4.
REQ-015 master_rdata  out  32  response data, broadcast to all masters.
REQ-016 resp_err  out  1  timeout indication, valid with master_k_ack.
REQ-017 arb_ack  out  1  completion pulse to the arbiter's slave_ack input.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, BUSY and RESP, with state and all outputs registered.
REQ-020 IDLE: when grant_req=1 and grant_num is 1..4, the block SHALL capture that master's addr, cmd and wdata together with grant_num, clear the timeout counter, and go to BUSY on the next edge.
REQ-021 IDLE: an illegal grant_num (0 or 5..7), or grant_req=0, SHALL leave the state in IDLE with no capture.
REQ-022 BUSY: slave_req=1, and slave_addr, slave_cmd and slave_wdata SHALL be held constant regardless of master input changes.
REQ-023 BUSY with slave_ack=1: the block SHALL capture slave_rdata, set resp_err to 0, and go to RESP.
REQ-024 BUSY with slave_ack=0: the 8-bit counter SHALL increment.
REQ-025 On the BUSY cycle where the counter reaches TIMEOUT-1 with no ack, the block SHALL go to RESP with master_rdata=32'h0000_0000 and resp_err=1.
REQ-026 slave_ack on the timeout cycle SHALL take priority, giving a normal completion.
REQ-027 RESP SHALL last exactly one cycle, in which:
- master_k_ack=1 only for the captured master;
- arb_ack=1;
- slave_req=0.
The FSM SHALL then go to IDLE.
REQ-028 slave_ack in IDLE or RESP SHALL be ignored.
REQ-029 grant_req in BUSY or RESP SHALL be ignored, so grant_num changes mid-transaction have no effect.
REQ-030 Latency:
- grant sampled at edge N gives slave_req=1 from cycle N+1;
- slave_ack sampled at edge M gives master_k_ack and arb_ack in cycle M+1;
- the next grant can be accepted at edge M+2.
REQ-031 master_rdata and resp_err SHALL hold their last values until the next RESP; master_k_ack and arb_ack SHALL be single-cycle pulses.

Reset
REQ-032 While reset=1 at a clock edge:
- state SHALL go to IDLE;
- slave_req, all master_k_ack, arb_ack, resp_err and busy SHALL be 0;
- slave_addr, slave_wdata and master_rdata SHALL be 0;
- slave_cmd and the counter SHALL be 0;
- the captured master number SHALL be 0.
REQ-033 Reset asserted in BUSY or RESP SHALL abort the transaction with no ack pulse to any master, in the cycle after reset is sampled or later.

Verification
REQ-034 Read path: grant_num=2 with grant_req=1 in IDLE, master_2 addr=32'h10, cmd=0; slave_ack with rdata=32'hCAFE0001 three cycles later -> slave_req high for 3 cycles, slave_addr=32'h10, then master_2_ack=1 and arb_ack=1 for one cycle, master_rdata=32'hCAFE0001, resp_err=0.
REQ-035 Hold stability: master_4 write accepted, then master_4 inputs and grant_num changed during BUSY -> slave_addr and slave_wdata remain the captured values until RESP.
REQ-036 Timeout: TIMEOUT=4 with slave_ack held 0 -> slave_req high for exactly 4 cycles, then master_k_ack=1, resp_err=1, master_rdata=0.
REQ-037 Illegal and spurious inputs:
- grant_num=0 or 5 with grant_req=1 -> stays IDLE;
- slave_ack pulsed in IDLE -> no master_k_ack or arb_ack.
REQ-038 Reset mid-transaction: reset asserted on the second BUSY cycle -> next cycle busy=0, slave_req=0, and no master_k_ack is ever produced for that transaction.
REQ-039 Back-to-back: grant 1 acked, then grant 3 presented continuously -> grant 3 accepted exactly 2 cycles after the ack edge, and the ack pulses go to master_1 then master_3 only.
